pe_psum_collector: RTL and testbench

- Sits directly downstream of the PE's O-channel (FP32 partial-sum output) and is the PE's O_DataOutRdy source.
- Buffers partial sums in a BufferSize-deep FIFO and counts results per tile.
- Presents results to the array writeback/drain logic over a valid/ready stream, with a last-of-tile marker and an occupancy count.
- Exerts backpressure on the PE when its FIFO is full.

---
 rtl/pe_pkg.sv | 16 +
 rtl/pe_sync_fifo.sv | 62 ++++++
 rtl/pe_psum_collector.sv | 98 +++++++++
 tb/tb_pe_psum_collector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants and helpers for the PE partial-sum collector.
package pe_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int BUFFER_WIDTH_DEF = 2;

  localparam int          EXP_MSB      = 30;
  localparam int          EXP_LSB      = 23;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;

  // One extra bit so a full FIFO (count == depth) is representable.
  function automatic int occ_width(input int buffer_width);
    return buffer_width + 1;
  endfunction

endpackage

// File: rtl/pe_sync_fifo.sv
// Single-clock FIFO with count-derived full/empty; head word reads as zero when empty.
module pe_sync_fifo
  import pe_pkg::*;
#(
  parameter int Width     = DATA_WIDTH_DEF + 1,
  parameter int AddrWidth = BUFFER_WIDTH_DEF,
  parameter int Depth     = 2 ** BUFFER_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push_i,
  input  logic                              pop_i,
  input  logic [Width-1:0]                  data_i,
  output logic [Width-1:0]                  data_o,
  output logic                              full_o,
  output logic                              empty_o,
  output logic [occ_width(AddrWidth)-1:0]   count_o
);

  localparam int CW = occ_width(AddrWidth);

  logic [Width-1:0]     mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == CW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AddrWidth'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AddrWidth'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; validity is tracked by count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pe_psum_collector.sv
// Buffers PE partial sums, tags last-of-tile and streams them out.
// Optional macro PSUM_NAN_CHECK_EN adds a sticky Inf/NaN flag (Psum_Err, Err_Clr).
module pe_psum_collector
  import pe_pkg::*;
#(
  parameter int DataWidth   = DATA_WIDTH_DEF,
  parameter int BufferWidth = BUFFER_WIDTH_DEF,
  parameter int BufferSize  = 2 ** BUFFER_WIDTH_DEF,
  parameter int TileLen     = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [DataWidth-1:0]                  Psum_DataIn,
  input  logic                                  Psum_DataInValid,
  output logic                                  Psum_DataInRdy,
  output logic [DataWidth-1:0]                  Res_DataOut,
  output logic                                  Res_DataOutValid,
  input  logic                                  Res_DataOutRdy,
  output logic                                  Res_Last,
  output logic [occ_width(BufferWidth)-1:0]     Occupancy,
  output logic                                  Tile_Done
`ifdef PSUM_NAN_CHECK_EN
  ,
  output logic                                  Psum_Err,
  input  logic                                  Err_Clr
`endif
);

  localparam int CntW = $clog2(TileLen + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TileLen - 1);

  logic                 fifo_full, fifo_empty;
  logic [DataWidth:0]   head;
  logic                 push, pop, last_tag;
  logic [CntW-1:0]      tile_cnt_q, tile_cnt_d;
  logic                 tile_done_q;

  assign Psum_DataInRdy   = !fifo_full;
  assign Res_DataOutValid = !fifo_empty;
  assign Res_DataOut      = head[DataWidth-1:0];
  assign Res_Last         = head[DataWidth];
  assign Tile_Done        = tile_done_q;

  assign push     = Psum_DataInValid && Psum_DataInRdy;
  assign pop      = Res_DataOutValid && Res_DataOutRdy;
  assign last_tag = (tile_cnt_q == LastCnt);

  pe_sync_fifo #(
    .Width     (DataWidth + 1),
    .AddrWidth (BufferWidth),
    .Depth     (BufferSize)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({last_tag, Psum_DataIn}),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (Occupancy)
  );

  always_comb begin
    tile_cnt_d = tile_cnt_q;
    if (push) tile_cnt_d = last_tag ? '0 : tile_cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_cnt_q  <= '0;
      tile_done_q <= 1'b0;
    end else begin
      tile_cnt_q  <= tile_cnt_d;
      tile_done_q <= pop && Res_Last;
    end
  end

`ifdef PSUM_NAN_CHECK_EN
  logic err_q, err_d, bad_exp;

  assign bad_exp  = (Psum_DataIn[EXP_MSB:EXP_LSB] == EXP_ALL_ONES);
  assign Psum_Err = err_q;

  // A fresh Inf/NaN in the same cycle as a clear keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (push && bad_exp) err_d = 1'b1;
    else if (Err_Clr)    err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_pe_psum_collector.sv
// Randomized and directed bench for pe_psum_collector against a queue-based model.
module tb_pe_psum_collector;

  localparam int TL = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Psum_DataIn;
  logic        Psum_DataInValid;
  logic        Psum_DataInRdy;
  logic [31:0] Res_DataOut;
  logic        Res_DataOutValid;
  logic        Res_DataOutRdy;
  logic        Res_Last;
  logic [2:0]  Occupancy;
  logic        Tile_Done;
  logic        Psum_Err;
  logic        Err_Clr;

  pe_psum_collector #(
    .DataWidth(32), .BufferWidth(2), .BufferSize(DEPTH), .TileLen(TL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .Psum_DataIn      (Psum_DataIn),
    .Psum_DataInValid (Psum_DataInValid),
    .Psum_DataInRdy   (Psum_DataInRdy),
    .Res_DataOut      (Res_DataOut),
    .Res_DataOutValid (Res_DataOutValid),
    .Res_DataOutRdy   (Res_DataOutRdy),
    .Res_Last         (Res_Last),
    .Occupancy        (Occupancy),
    .Tile_Done        (Tile_Done)
`ifdef PSUM_NAN_CHECK_EN
    ,
    .Psum_Err         (Psum_Err),
    .Err_Clr          (Err_Clr)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [32:0] mq[$];
  int          m_tile;
  logic        m_done;
  logic        m_err;
  int          done_seen;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tile = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs();
    logic [32:0] h;
    h = (mq.size() != 0) ? mq[0] : 33'h0;
    chk("valid", 64'(Res_DataOutValid), 64'(mq.size() != 0));
    chk("data",  64'(Res_DataOut),      64'(h[31:0]));
    chk("last",  64'(Res_Last),         64'(h[32]));
    chk("occ",   64'(Occupancy),        64'(mq.size()));
    chk("in_rdy", 64'(Psum_DataInRdy),  64'(mq.size() != DEPTH));
    chk("done",  64'(Tile_Done),        64'(m_done));
`ifdef PSUM_NAN_CHECK_EN
    chk("err",   64'(Psum_Err),         64'(m_err));
`endif
    if (Tile_Done === 1'b1) done_seen++;
  endtask

  // Check the state left by the previous edge, then drive and predict the next edge.
  task automatic step(input logic vin, input logic [31:0] din, input logic rout, input logic clr);
    bit push, pop;
    @(negedge clk);
    check_outputs();
    Psum_DataInValid = vin;
    Psum_DataIn      = din;
    Res_DataOutRdy   = rout;
    Err_Clr          = clr;
    push = vin && (mq.size() < DEPTH);
    pop  = rout && (mq.size() > 0);
    m_done = pop && mq[0][32];
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back({m_tile == TL - 1, din});
      m_tile = (m_tile + 1) % TL;
      if (din[30:23] == 8'hFF) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end else if (clr) begin
      m_err = 1'b0;
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    Psum_DataInValid = 1'b0;
    Res_DataOutRdy   = 1'b0;
    Err_Clr          = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    rst = 1'b1;
    Psum_DataIn = '0; Psum_DataInValid = 1'b0; Res_DataOutRdy = 1'b0; Err_Clr = 1'b0;
    model_reset();
    done_seen = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Single word through an empty FIFO.
    step(1, 32'h42C80000, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // Fill, hold a 5th word, then release.
    mid_reset();
    for (int i = 0; i < 4; i++) step(1, (i % 2) ? 32'h46A41000 : 32'h42C80000, 0, 0);
    step(1, 32'h12345678, 0, 0);
    step(1, 32'h12345678, 0, 0);
    step(1, 32'h12345678, 1, 0);
    step(1, 32'h12345678, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 4; i++) step(1, 32'hA0000000 + i, 0, 0);
    step(1, 32'hB0000001, 1, 0);
    step(1, 32'hB0000002, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);

    // Two tiles of three, free drain; count Tile_Done pulses.
    mid_reset();
    done_seen = 0;
    for (int i = 0; i < 6; i++) step(1, 32'hC0000000 + i, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("tile_done_pulses", 64'(done_seen), 64'd2);

    // Reset with two words buffered; next tile restarts at word 1.
    mid_reset();
    step(1, 32'hD0000001, 0, 0);
    step(1, 32'hD0000002, 0, 0);
    mid_reset();
    for (int i = 0; i < 3; i++) step(1, 32'hE0000000 + i, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

    // NaN, then normal words, then a clear.
    step(1, 32'h7FC00000, 1, 0);
    step(1, 32'h42C80000, 1, 0);
    step(1, 32'h42C80000, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(1, 32'h7F800000, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      d = $urandom;
      if ($urandom_range(0, 7) == 0) d[30:23] = 8'hFF;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) mid_reset();
    end
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
